// File: rtl/dm_lane_unit.sv
// Data-memory byte-lane unit: store lane steering and byte enables in M,
// load sub-word extraction with a stall-safe read-data hold buffer in W.
module dm_lane_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m_en,
    input  logic [3:0]  i_m_op,
    input  logic [31:0] i_m_addr,
    input  logic [31:0] i_m_wdata,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [31:0] o_dm_addr,
    output logic [3:0]  o_dm_be,
    output logic [31:0] o_dm_wdata,
    input  logic [31:0] i_dm_rdata,
    output logic        o_m_adel,
    output logic        o_m_ades,
    output logic        o_w_valid,
    output logic [31:0] o_w_ldata
);
    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } op_t;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_mis;
    logic [3:0]  w_be_raw;
    logic [31:0] w_wdata;
    logic        w_adv;

    op_t         r_w_op;
    logic [1:0]  r_w_lo;
    logic        r_w_valid;
    logic        r_hold_valid;
    logic [31:0] r_hold_data;

    logic [31:0] w_src;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_ext;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_mis      = 1'b0;
        w_be_raw   = 4'b0000;
        w_wdata    = i_m_wdata;
        case (i_m_op)
            OP_LW: begin
                w_is_load = 1'b1;
                w_mis     = |i_m_addr[1:0];
            end
            OP_LH, OP_LHU: begin
                w_is_load = 1'b1;
                w_mis     = i_m_addr[0];
            end
            OP_LB, OP_LBU: begin
                w_is_load = 1'b1;
            end
            OP_SW: begin
                w_is_store = 1'b1;
                w_mis      = |i_m_addr[1:0];
                w_be_raw   = 4'b1111;
            end
            OP_SH: begin
                w_is_store = 1'b1;
                w_mis      = i_m_addr[0];
                w_be_raw   = i_m_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{i_m_wdata[15:0]}};
            end
            OP_SB: begin
                w_is_store = 1'b1;
                w_be_raw   = 4'b0001 << i_m_addr[1:0];
                w_wdata    = {4{i_m_wdata[7:0]}};
            end
            default: begin
                w_is_load  = 1'b0;
                w_is_store = 1'b0;
            end
        endcase
    end

    // A stalled store must not write; it commits on the cycle stall drops.
    assign o_dm_addr  = {i_m_addr[31:2], 2'b00};
    assign o_dm_wdata = w_wdata;
    assign o_dm_be    = (i_m_en && w_is_store && !w_mis && !i_stall)
                        ? w_be_raw : 4'b0000;
    assign o_m_adel   = i_m_en & w_is_load & w_mis;
    assign o_m_ades   = i_m_en & w_is_store & w_mis;
    assign w_adv      = i_m_en & w_is_load & ~w_mis & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_w_op       <= OP_NONE;
            r_w_lo       <= 2'b00;
            r_w_valid    <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= 32'h0;
        end else if (i_stall) begin
            if (r_w_valid && !r_hold_valid) begin
                r_hold_data  <= i_dm_rdata;
                r_hold_valid <= 1'b1;
            end
        end else begin
            r_hold_valid <= 1'b0;
            if (w_adv) begin
                r_w_op    <= op_t'(i_m_op);
                r_w_lo    <= i_m_addr[1:0];
                r_w_valid <= 1'b1;
            end else begin
                r_w_op    <= OP_NONE;
                r_w_valid <= 1'b0;
            end
        end
    end

    // DM word is only on the bus the first W cycle; later cycles use the copy.
    assign w_src  = r_hold_valid ? r_hold_data : i_dm_rdata;
    assign w_half = r_w_lo[1] ? w_src[31:16] : w_src[15:0];
    assign w_byte = w_src[{r_w_lo, 3'b000} +: 8];

    always_comb begin
        case (r_w_op)
            OP_LW:   w_ext = w_src;
            OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ext = {16'h0, w_half};
            OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ext = {24'h0, w_byte};
            default: w_ext = 32'h0;
        endcase
    end

    assign o_w_valid = r_w_valid;
    assign o_w_ldata = r_w_valid ? w_ext : 32'h0;
endmodule
